demux_write_bank: RTL and testbench

DEMUX_WRITE_BANK -- requirements
Module: demux_write_bank

---
 rtl/demux_write_bank_pkg.sv | 29 ++
 rtl/demux_write_bank_if.sv | 26 ++
 rtl/decoder4_16.sv | 15 +
 rtl/demux_write_bank_defs.svh | 10 +
 rtl/demux_write_bank.sv | 125 ++++++++++++
 tb/tb_demux_write_bank.sv | 196 +++++++++++++++++++
 6 files changed

// File: rtl/demux_write_bank_pkg.sv
// Common types and helpers for the demux write bank.
package demux_write_bank_pkg;

`include "demux_write_bank_defs.svh"

  localparam int unsigned NREGS  = `DWB_NREGS;
  localparam int unsigned DATA_W = `DWB_DATA_W;
  localparam int unsigned IDX_W  = `DWB_IDX_W;
  localparam int unsigned BE_W   = `DWB_BE_W;

  typedef struct packed {
    logic [IDX_W-1:0]  addr;
    logic [DATA_W-1:0] data;
    logic [BE_W-1:0]   be;
  } wr_entry_t;

  // Byte-lane merge: lanes with be=0 keep the current value.
  function automatic logic [DATA_W-1:0] merge_bytes(input logic [DATA_W-1:0] cur,
                                                    input logic [DATA_W-1:0] nxt,
                                                    input logic [BE_W-1:0]   be);
    logic [DATA_W-1:0] res;
    res = cur;
    for (int b = 0; b < BE_W; b++) begin
      if (be[b]) res[8*b +: 8] = nxt[8*b +: 8];
    end
    return res;
  endfunction

endpackage

// File: rtl/demux_write_bank_if.sv
// Write-request handshake bundle between a requester and the write bank.
interface demux_write_bank_if;
  import demux_write_bank_pkg::*;

  logic              wr_valid;
  logic              wr_ready;
  logic [IDX_W-1:0]  wr_addr;
  logic [DATA_W-1:0] wr_data;
  logic [BE_W-1:0]   wr_be;

  modport master (
    output wr_valid,
    output wr_addr,
    output wr_data,
    output wr_be,
    input  wr_ready
  );

  modport slave (
    input  wr_valid,
    input  wr_addr,
    input  wr_data,
    input  wr_be,
    output wr_ready
  );
endinterface

// File: rtl/decoder4_16.sv
// Index to one-hot register write strobes, all zero unless enabled.
module decoder4_16
  import demux_write_bank_pkg::*;
(
  input  logic [IDX_W-1:0] idx,
  input  logic             en,
  output logic [NREGS-1:0] strobe
);

  always_comb begin
    strobe = '0;
    if (en) strobe[idx] = 1'b1;
  end

endmodule

// File: rtl/demux_write_bank_defs.svh
// Shared sizing macros for the write bank: register count, data, index and byte-enable widths.
`ifndef DEMUX_WRITE_BANK_DEFS_SVH
`define DEMUX_WRITE_BANK_DEFS_SVH

`define DWB_NREGS  16
`define DWB_DATA_W 32
`define DWB_IDX_W  4
`define DWB_BE_W   4

`endif

// File: rtl/demux_write_bank.sv
// Sixteen-register bank fed by a 2-entry in-order write queue with byte enables and hold.
module demux_write_bank
  import demux_write_bank_pkg::*;
#(
  parameter int unsigned DATA_WIDTH = DATA_W,
  parameter int unsigned QDEPTH     = 2
) (
  input  logic                  clk,
  input  logic                  reset_n,
  demux_write_bank_if.slave     wr,
  input  logic                  hold,
  output logic [DATA_WIDTH-1:0] reg_out1,
  output logic [DATA_WIDTH-1:0] reg_out2,
  output logic [DATA_WIDTH-1:0] reg_out3,
  output logic [DATA_WIDTH-1:0] reg_out4,
  output logic [DATA_WIDTH-1:0] reg_out5,
  output logic [DATA_WIDTH-1:0] reg_out6,
  output logic [DATA_WIDTH-1:0] reg_out7,
  output logic [DATA_WIDTH-1:0] reg_out8,
  output logic [DATA_WIDTH-1:0] reg_out9,
  output logic [DATA_WIDTH-1:0] reg_out10,
  output logic [DATA_WIDTH-1:0] reg_out11,
  output logic [DATA_WIDTH-1:0] reg_out12,
  output logic [DATA_WIDTH-1:0] reg_out13,
  output logic [DATA_WIDTH-1:0] reg_out14,
  output logic [DATA_WIDTH-1:0] reg_out15,
  output logic [DATA_WIDTH-1:0] reg_out16,
  output logic [1:0]            pending,
  output logic                  done,
  output logic [IDX_W-1:0]      done_addr
);

  wr_entry_t              queue_q [QDEPTH];
  logic                   head_q, tail_q;
  logic [1:0]             count_q, count_d;
  logic                   ready_en_q;
  logic                   done_q;
  logic [IDX_W-1:0]       done_addr_q;
  logic [DATA_WIDTH-1:0]  bank_q [NREGS];

  wr_entry_t              head_entry;
  logic                   full, accept, commit;
  logic [NREGS-1:0]       strobe;

  assign head_entry = queue_q[head_q];
  assign full       = (count_q == 2'(QDEPTH));
  // ready_en_q keeps ready low until one edge has passed with reset released.
  assign wr.wr_ready = reset_n & ready_en_q & ~full;
  assign accept      = wr.wr_valid & wr.wr_ready;
  assign commit      = (count_q != 2'd0) & ~hold;

  always_comb begin
    count_d = count_q;
    case ({accept, commit})
      2'b10:   count_d = count_q + 2'd1;
      2'b01:   count_d = count_q - 2'd1;
      default: count_d = count_q;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      head_q      <= 1'b0;
      tail_q      <= 1'b0;
      count_q     <= 2'd0;
      ready_en_q  <= 1'b0;
      done_q      <= 1'b0;
      done_addr_q <= '0;
    end else begin
      ready_en_q <= 1'b1;
      count_q    <= count_d;
      done_q     <= commit;
      if (accept) tail_q <= ~tail_q;
      if (commit) begin
        head_q      <= ~head_q;
        done_addr_q <= head_entry.addr;
      end
    end
  end

  // Entry storage needs no reset; validity is tracked by count_q.
  always_ff @(posedge clk) begin
    if (reset_n && accept) begin
      queue_q[tail_q] <= '{addr: wr.wr_addr, data: wr.wr_data, be: wr.wr_be};
    end
  end

  decoder4_16 u_decoder (
    .idx    (head_entry.addr),
    .en     (commit),
    .strobe (strobe)
  );

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      for (int k = 0; k < NREGS; k++) bank_q[k] <= '0;
    end else begin
      for (int k = 0; k < NREGS; k++) begin
        if (strobe[k]) bank_q[k] <= merge_bytes(bank_q[k], head_entry.data, head_entry.be);
      end
    end
  end

  assign pending   = count_q;
  assign done      = done_q;
  assign done_addr = done_addr_q;

  assign reg_out1  = bank_q[0];
  assign reg_out2  = bank_q[1];
  assign reg_out3  = bank_q[2];
  assign reg_out4  = bank_q[3];
  assign reg_out5  = bank_q[4];
  assign reg_out6  = bank_q[5];
  assign reg_out7  = bank_q[6];
  assign reg_out8  = bank_q[7];
  assign reg_out9  = bank_q[8];
  assign reg_out10 = bank_q[9];
  assign reg_out11 = bank_q[10];
  assign reg_out12 = bank_q[11];
  assign reg_out13 = bank_q[12];
  assign reg_out14 = bank_q[13];
  assign reg_out15 = bank_q[14];
  assign reg_out16 = bank_q[15];

endmodule

// File: tb/tb_demux_write_bank.sv
// Randomised and directed bench for demux_write_bank against a queue-based reference model.
module tb_demux_write_bank;

  logic        clk;
  logic        reset_n;
  logic        hold;
  logic [31:0] reg_out [16];
  logic [1:0]  pending;
  logic        done;
  logic [3:0]  done_addr;

  demux_write_bank_if bus ();

  demux_write_bank u_dut (
    .clk       (clk),
    .reset_n   (reset_n),
    .wr        (bus),
    .hold      (hold),
    .reg_out1  (reg_out[0]),
    .reg_out2  (reg_out[1]),
    .reg_out3  (reg_out[2]),
    .reg_out4  (reg_out[3]),
    .reg_out5  (reg_out[4]),
    .reg_out6  (reg_out[5]),
    .reg_out7  (reg_out[6]),
    .reg_out8  (reg_out[7]),
    .reg_out9  (reg_out[8]),
    .reg_out10 (reg_out[9]),
    .reg_out11 (reg_out[10]),
    .reg_out12 (reg_out[11]),
    .reg_out13 (reg_out[12]),
    .reg_out14 (reg_out[13]),
    .reg_out15 (reg_out[14]),
    .reg_out16 (reg_out[15]),
    .pending   (pending),
    .done      (done),
    .done_addr (done_addr)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [3:0]  a;
    logic [31:0] d;
    logic [3:0]  be;
  } ent_t;

  // Reference model state
  logic [31:0] m_bank [16];
  ent_t        m_q [$];
  logic        m_done;
  logic [3:0]  m_daddr;
  logic        m_rdy_en;

  int n_vec;
  int n_err;

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %h, expected %h", tag, obs, exp);
    end
  endtask

  task automatic drive_cycle(input logic rst, input logic v, input logic [3:0] a,
                             input logic [31:0] d, input logic [3:0] be, input logic h);
    logic m_ready;
    ent_t e;
    reset_n      = rst;
    bus.wr_valid = v;
    bus.wr_addr  = a;
    bus.wr_data  = d;
    bus.wr_be    = be;
    hold         = h;
    @(negedge clk);
    m_ready = rst && m_rdy_en && (m_q.size() < 2);
    check_eq("wr_ready", 32'(bus.wr_ready), 32'(m_ready));
    if (!rst) begin
      for (int i = 0; i < 16; i++) m_bank[i] = '0;
      m_q.delete();
      m_done   = 1'b0;
      m_daddr  = '0;
      m_rdy_en = 1'b0;
    end else begin
      if (m_q.size() > 0 && !h) begin
        e = m_q.pop_front();
        for (int b = 0; b < 4; b++) begin
          if (e.be[b]) m_bank[e.a][8*b +: 8] = e.d[8*b +: 8];
        end
        m_done  = 1'b1;
        m_daddr = e.a;
      end else begin
        m_done = 1'b0;
      end
      if (v && m_ready) begin
        e.a  = a;
        e.d  = d;
        e.be = be;
        m_q.push_back(e);
      end
      m_rdy_en = 1'b1;
    end
    @(posedge clk);
    #1;
    check_eq("pending", 32'(pending), 32'(m_q.size()));
    check_eq("done", 32'(done), 32'(m_done));
    check_eq("done_addr", 32'(done_addr), 32'(m_daddr));
    for (int i = 0; i < 16; i++) begin
      check_eq($sformatf("reg_out%0d", i + 1), reg_out[i], m_bank[i]);
    end
  endtask

  task automatic idle(input logic h);
    drive_cycle(1'b1, 1'b0, 4'h0, 32'h0, 4'h0, h);
  endtask

  initial begin
    n_vec = 0;
    n_err = 0;
    for (int i = 0; i < 16; i++) m_bank[i] = '0;
    m_done   = 1'b0;
    m_daddr  = '0;
    m_rdy_en = 1'b0;
    reset_n      = 1'b0;
    hold         = 1'b0;
    bus.wr_valid = 1'b0;
    bus.wr_addr  = '0;
    bus.wr_data  = '0;
    bus.wr_be    = '0;
    @(posedge clk);
    #1;

    // Reset, then one released edge before ready rises
    drive_cycle(1'b0, 1'b0, 4'h0, 32'h0, 4'h0, 1'b0);
    drive_cycle(1'b0, 1'b1, 4'h1, 32'h1111_1111, 4'hF, 1'b0);
    idle(1'b0);
    check_eq("ready_after_reset", 32'(bus.wr_ready), 32'd1);

    // Full-word write then partial-byte overwrite
    drive_cycle(1'b1, 1'b1, 4'd5, 32'hDEAD_BEEF, 4'hF, 1'b0);
    check_eq("req033_pending", 32'(pending), 32'd1);
    idle(1'b0);
    check_eq("req033_reg6", reg_out[5], 32'hDEAD_BEEF);
    check_eq("req033_done", 32'(done), 32'd1);
    check_eq("req033_done_addr", 32'(done_addr), 32'd5);
    drive_cycle(1'b1, 1'b1, 4'd5, 32'h0000_1234, 4'b0011, 1'b0);
    idle(1'b0);
    check_eq("req034_reg6", reg_out[5], 32'hDEAD_1234);
    idle(1'b0);

    // Hold: three back-to-back requests, third stalls until the queue drains
    drive_cycle(1'b1, 1'b1, 4'd1, 32'hA1, 4'hF, 1'b1);
    drive_cycle(1'b1, 1'b1, 4'd2, 32'hA2, 4'hF, 1'b1);
    drive_cycle(1'b1, 1'b1, 4'd3, 32'hA3, 4'hF, 1'b1);
    check_eq("req035_pending_full", 32'(pending), 32'd2);
    drive_cycle(1'b1, 1'b1, 4'd3, 32'hA3, 4'hF, 1'b0);
    drive_cycle(1'b1, 1'b1, 4'd3, 32'hA3, 4'hF, 1'b0);
    idle(1'b0);
    idle(1'b0);
    check_eq("req035_reg4", reg_out[3], 32'hA3);

    // Same index twice, last write wins; zero byte-enable still commits
    drive_cycle(1'b1, 1'b1, 4'd3, 32'd1, 4'hF, 1'b0);
    drive_cycle(1'b1, 1'b1, 4'd3, 32'd2, 4'hF, 1'b0);
    check_eq("req036_first", reg_out[3], 32'd1);
    idle(1'b0);
    check_eq("req036_second", reg_out[3], 32'd2);
    drive_cycle(1'b1, 1'b1, 4'd15, 32'hFFFF_FFFF, 4'h0, 1'b0);
    idle(1'b0);
    check_eq("be0_done", 32'(done), 32'd1);
    check_eq("be0_reg16", reg_out[15], 32'h0);

    // Reset with a full queue discards everything
    drive_cycle(1'b1, 1'b1, 4'd7, 32'h77, 4'hF, 1'b1);
    drive_cycle(1'b1, 1'b1, 4'd8, 32'h88, 4'hF, 1'b1);
    drive_cycle(1'b0, 1'b1, 4'd9, 32'h99, 4'hF, 1'b0);
    check_eq("req037_pending", 32'(pending), 32'd0);
    check_eq("req037_reg6", reg_out[5], 32'h0);
    idle(1'b0);
    check_eq("req037_done", 32'(done), 32'd0);
    idle(1'b0);

    // Randomised traffic with occasional hold and reset
    for (int n = 0; n < 600; n++) begin
      drive_cycle(($urandom_range(0, 59) != 0), ($urandom_range(0, 9) < 6),
                  4'($urandom_range(0, 15)), $urandom(), 4'($urandom_range(0, 15)),
                  ($urandom_range(0, 9) < 3));
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
